sc_switch_in_port: RTL

SC_SWITCH_IN_PORT -- requirements
Module: sc_switch_in_port

---
 rtl/sc_io_pkg.sv | 17 +
 rtl/sc_sync2.sv | 27 ++
 rtl/sc_switch_in_port.sv | 100 ++++++++++
 3 files changed

// File: rtl/sc_io_pkg.sv
// Shared constants for the slide-switch input port: default width,
// CPU register map and the port identification word.
package sc_io_pkg;

    localparam int unsigned SW_WIDTH = 10;

    // CPU-visible register select values (io_addr)
    typedef enum logic [1:0] {
        REG_STABLE = 2'd0,
        REG_CHG    = 2'd1,
        REG_STATUS = 2'd2,
        REG_ID     = 2'd3
    } io_reg_e;

    localparam logic [31:0] PORT_ID = 32'h5357_0001;

endpackage

// File: rtl/sc_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous level inputs.
module sc_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Two-stage resynchronisation into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/sc_switch_in_port.sv
// Slide-switch input port: synchronise, debounce the whole vector with a
// single candidate/counter pair, latch per-bit change flags and expose
// everything through a small registered CPU read interface.
module sc_switch_in_port
    import sc_io_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = sc_io_pkg::SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                io_rd,
    input  logic [1:0]          io_addr,
    output logic [31:0]         io_read_data,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                change_irq
);

    localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] s2;
    logic [SW_WIDTH-1:0] cand;
    logic [CNT_W-1:0]    cnt;
    logic [SW_WIDTH-1:0] chg;
    logic [SW_WIDTH-1:0] new_bits;
    logic [SW_WIDTH-1:0] rd_clr;
    logic [31:0]         rd_mux;

    sc_sync2 #(
        .WIDTH (SW_WIDTH)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw),
        .q     (s2)
    );

    // Bits that flip on a commit this cycle, and flags cleared by an addr1 read
    always_comb begin
        new_bits = '0;
        rd_clr   = '0;
        if ((s2 == cand) && (cnt == CNT_MAX) && (cand != sw_stable)) begin
            new_bits = cand ^ sw_stable;
        end
        if (io_rd && (io_reg_e'(io_addr) == REG_CHG)) begin
            rd_clr = chg;
        end
    end

    // Debounce: restart on any change, saturate the counter, commit when settled
    always_ff @(posedge clock) begin
        if (reset) begin
            cand      <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (cand != sw_stable) begin
            sw_stable <= cand;
        end
    end

    // Sticky change flags; a set on the same edge as a read-clear wins
    always_ff @(posedge clock) begin
        if (reset) begin
            chg <= '0;
        end else begin
            chg <= (chg & ~rd_clr) | new_bits;
        end
    end

    // Register select for CPU reads (pre-edge values)
    always_comb begin
        rd_mux = '0;
        case (io_reg_e'(io_addr))
            REG_STABLE: rd_mux = 32'(sw_stable);
            REG_CHG:    rd_mux = 32'(chg);
            REG_STATUS: rd_mux = 32'(change_irq);
            REG_ID:     rd_mux = PORT_ID;
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, held while no read strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            io_read_data <= '0;
        end else if (io_rd) begin
            io_read_data <= rd_mux;
        end
    end

    assign change_irq = |chg;

endmodule
